// File: rtl/fa4_serial.sv
// rtl/fa4_serial.sv - bit-serial WIDTH-bit adder, one full-adder cell reused per cycle
// Optional built-in result checker enabled by FA4_SERIAL_CHECK_EN.
module fa4_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_full;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last_shift, sum_bit, carry_nxt;

    assign accept     = in_valid && in_ready;
    assign last_shift = (state == SHIFT) && (cnt == LAST);
    assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt  = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0
    assign sum_full   = {sum_bit, sum_sh};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            co     <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= ci;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_full[WIDTH-1:1];
            carry  <= carry_nxt;
            cnt    <= cnt + CW'(1);
            if (last_shift) begin
                s  <= sum_full;
                co <= carry_nxt;
            end
        end
    end

`ifdef FA4_SERIAL_CHECK_EN
    logic [WIDTH:0] exp_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_sum <= '0;
            err     <= 1'b0;
        end else begin
            if (accept)
                exp_sum <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
            if (last_shift && ({carry_nxt, sum_full} != exp_sum))
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fa4_serial.sv
// tb/tb_fa4_serial.sv - directed and random self-checking bench for fa4_serial
module tb_fa4_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       ci = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] s;
    logic       co;
    logic       err;

    int tests = 0;
    int failed = 0;

    fa4_serial #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .co       (co),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    // Accept one operand set, check latency and result, stall, then release.
    task automatic run_txn(input logic [3:0] ta, input logic [3:0] tb2, input logic tci,
                           input logic [3:0] exp_s, input logic exp_co, input int stall);
        int edges;
        logic [3:0] s0;
        logic co0;
        wait_ready();
        in_valid = 1'b1;
        a = ta;
        b = tb2;
        ci = tci;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency", edges, 5);
        check("sum", {28'b0, s}, {28'b0, exp_s});
        check("carry", {31'b0, co}, {31'b0, exp_co});
        s0 = s;
        co0 = co;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_s", {28'b0, s}, {28'b0, s0});
            check("stall_co", {31'b0, co}, {31'b0, co0});
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", {31'b0, out_valid}, 32'd0);
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic       rc;
        logic [4:0] rsum;
        logic       seen;

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_s", {28'b0, s}, 32'd0);
        check("rst_co", {31'b0, co}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);

        run_txn(4'd9, 4'd8, 1'b1, 4'd2, 1'b1, 0);
        run_txn(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 0);
        run_txn(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 0);
        run_txn(4'd7, 4'd6, 1'b0, 4'd13, 1'b0, 10);

        // Operand change during SHIFT with in_valid held must be ignored
        wait_ready();
        in_valid = 1'b1;
        a = 4'd3;
        b = 4'd4;
        ci = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 4'd12;
        check("shift_in_ready", {31'b0, in_ready}, 32'd0);
        check("shift_hold_s", {28'b0, s}, 32'd13);
        begin
            int n = 0;
            while (!out_valid && n < 40) begin
                @(posedge clk);
                @(negedge clk);
                n++;
            end
        end
        check("hold_in_valid_sum", {28'b0, s}, 32'd7);
        check("hold_in_valid_co", {31'b0, co}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_release_ready", {31'b0, in_ready}, 32'd1);

        // Reset after two SHIFT edges aborts the transaction
        in_valid = 1'b1;
        a = 4'd9;
        b = 4'd8;
        ci = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_high_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_s", {28'b0, s}, 32'd0);
        check("abort_co", {31'b0, co}, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_output", {31'b0, seen}, 32'd0);
        run_txn(4'd5, 4'd6, 1'b0, 4'd11, 1'b0, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            rsum = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
            run_txn(ra, rb, rc, rsum[3:0], rsum[4], 0);
        end
        check("err_after_random", {31'b0, err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fa4_serial.md
FA4_SERIAL -- requirements
Module: fa4_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/sum width in bits (legal 2..16).
REQ-002 SHALL have clock and reset as decided: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand set {ci,a,b} presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  addend A.
REQ-008 b  input  WIDTH  addend B.
REQ-009 ci  input  1  carry in.
REQ-010 out_valid  output  1  result {co,s} valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 s  output  WIDTH  sum.
REQ-013 co  output  1  carry out.
REQ-014 err  output  1  sticky self-check mismatch flag (see Configuration).

Function
REQ-015 SHALL compute {co,s} = a + b + ci, bit-serially, LSB first, with one full-adder cell reused per cycle.
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE with rst low; in_valid outside IDLE SHALL be ignored, operands not captured.
REQ-018 Accept edge (in_valid && in_ready): load a, b into shift registers, carry register <= ci, bit counter <= 0, state -> SHIFT.
REQ-019 Each SHIFT edge: sum bit = a0^b0^carry shifted into sum register MSB, carry <= majority(a0,b0,carry), operands shift right, counter +1.
REQ-020 On the WIDTH-th SHIFT edge: s <= full sum register, co <= final carry, state -> DONE.
REQ-021 Latency: out_valid SHALL rise exactly WIDTH+1 rising edges after the accept edge (edge counting includes the DONE-entry edge: accept, WIDTH shift edges, out_valid visible after last).
REQ-022 out_valid SHALL be 1 only in DONE; s, co SHALL hold stable while out_valid && !out_ready, for any stall length.
REQ-023 Edge with out_valid && out_ready: state -> IDLE; in_ready high the following cycle; no same-cycle re-accept.
REQ-024 s, co SHALL change only on DONE entry or reset; they retain last result in IDLE and SHIFT.
REQ-025 Counter wrap: counter SHALL be WIDTH-sized to count to WIDTH without overflow; never wraps within a transaction.
REQ-026 Overflow: a+b+ci ≥ 2^WIDTH SHALL set co=1 with s = low WIDTH bits.

Reset
REQ-027 rst high at an edge SHALL force state IDLE, s=0, co=0, out_valid=0, err=0, internal registers 0, regardless of state (incl. mid-SHIFT, mid-stall).
REQ-028 in_ready SHALL be 0 while rst is high; first accept possible on first edge with rst low.
REQ-029 A transaction aborted by reset SHALL produce no output.

Configuration
REQ-030 Macro FA4_SERIAL_CHECK_EN SHALL gate a built-in checker.
REQ-031 With FA4_SERIAL_CHECK_EN defined: capture a+b+ci (WIDTH+1 bits) at accept; on DONE entry compare to {co,s}; mismatch sets err, sticky until reset.
REQ-032 Without the macro: no checker logic, err tied 0, all other behaviour identical.

Verification
REQ-033 a=9, b=8, ci=1, accept -> out_valid after 5 edges, s=2, co=1.
REQ-034 a=15, b=15, ci=1 -> s=15, co=1; a=0, b=0, ci=0 -> s=0, co=0.
REQ-035 Result with out_ready=0 for 10 cycles -> s, co, out_valid constant, in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-036 in_valid held high with a=3 changing to a=12 during SHIFT -> result reflects a=3 only.
REQ-037 rst pulsed after 2 SHIFT edges -> out_valid never asserts, s=0, co=0; next transaction a=5, b=6, ci=0 -> s=11, co=0.
REQ-038 With FA4_SERIAL_CHECK_EN, 1000 random {ci,a,b} back-to-back -> err stays 0; each result equals a+b+ci.
